// File: rtl/song_record_writer_pkg.sv
// Definitions shared by the record path, the auto-play path and the song memory.
package song_record_writer_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NOTE_W = 4;
    localparam int DEF_DUR_W  = 26;

    localparam int NOTE_REST = 0;

    // Terminator entry: auto-play stops when it reads isvalid=0
    localparam int   TERM_NOTE    = 0;
    localparam int   TERM_DUR     = 0;
    localparam logic TERM_ISVALID = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_TERM    = 3'd4,
        ST_DONE    = 3'd5
    } rec_state_t;

endpackage

// File: rtl/song_record_writer_rec_segment_timer.sv
// Saturating segment-duration counter with a minimum-length flag for glitch rejection.
module rec_segment_timer #(
    parameter int          DUR_W   = 26,
    parameter int unsigned MIN_DUR = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    input  logic             clr,
    output logic [DUR_W-1:0] cnt,
    output logic             long_enough
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= DUR_W'(1);
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + DUR_W'(1);
        end
    end

    assign long_enough = (64'(cnt) >= 64'(MIN_DUR));

endmodule

// File: rtl/song_record_writer.sv
// Records live keyboard notes and held durations as (note, duration, isvalid) song-memory entries.
module song_record_writer
    import song_record_writer_pkg::*;
#(
    parameter int          ADDR_W  = DEF_ADDR_W,
    parameter int          NOTE_W  = DEF_NOTE_W,
    parameter int          DUR_W   = DEF_DUR_W,
    parameter int unsigned MIN_DUR = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rec_button,
    input  logic              key_on,
    input  logic [NOTE_W-1:0] key,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [NOTE_W-1:0] wr_note,
    output logic [DUR_W-1:0]  wr_duration,
    output logic              wr_isvalid,
    output logic [ADDR_W-1:0] song_len,
    output logic              recording,
    output logic              full
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [NOTE_W-1:0] REST = NOTE_W'(NOTE_REST);

    rec_state_t        state, state_n;
    logic [NOTE_W-1:0] eff, cur, cur_n;
    logic [ADDR_W-1:0] addr;
    logic [DUR_W-1:0]  cnt;
    logic              long_enough;
    logic              commit_p0, commit_go, term_p0;
    logic              arm, set_full, last_slot;
    logic              tmr_load, tmr_inc, tmr_clr;

    assign eff       = key_on ? key : REST;
    assign last_slot = (addr == ADDR_W'(DEPTH - 2));
    assign recording = (state == ST_ARMED) || (state == ST_CAPTURE);

    // A segment ends on an eff change in CAPTURE, or is flushed on stop unless it is a rest
    assign commit_p0 = ((state == ST_CAPTURE) && (eff != cur)) ||
                       ((state == ST_FLUSH) && (cur != REST));
    assign commit_go = commit_p0 && long_enough;

    rec_segment_timer #(
        .DUR_W  (DUR_W),
        .MIN_DUR(MIN_DUR)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load),
        .inc        (tmr_inc),
        .clr        (tmr_clr),
        .cnt        (cnt),
        .long_enough(long_enough)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        cur_n    = cur;
        term_p0  = 1'b0;
        arm      = 1'b0;
        set_full = 1'b0;
        tmr_load = 1'b0;
        tmr_inc  = 1'b0;
        tmr_clr  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (rec_button) begin
                    state_n = ST_ARMED;
                    cur_n   = REST;
                    arm     = 1'b1;
                    tmr_clr = 1'b1;
                end
            end
            ST_ARMED: begin
                if (rec_button) begin
                    state_n = ST_FLUSH;
                end else if (eff != REST) begin
                    state_n  = ST_CAPTURE;
                    cur_n    = eff;
                    tmr_load = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (rec_button) begin
                    state_n = ST_FLUSH;
                    // old segment commits now; the new one is dropped
                    if (eff != cur) begin
                        cur_n = REST;
                    end
                end else if (eff != cur) begin
                    cur_n    = eff;
                    tmr_load = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
                if (commit_go && last_slot) begin
                    state_n  = ST_TERM;
                    set_full = 1'b1;
                end
            end
            ST_FLUSH: begin
                state_n = ST_TERM;
                if (commit_go && last_slot) begin
                    set_full = 1'b1;
                end
            end
            ST_TERM: begin
                term_p0 = 1'b1;
                state_n = ST_DONE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Write-port register stage: outputs hold their last values between strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur         <= '0;
            addr        <= '0;
            song_len    <= '0;
            full        <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_note     <= '0;
            wr_duration <= '0;
            wr_isvalid  <= 1'b0;
        end else begin
            cur   <= cur_n;
            wr_en <= commit_go || term_p0;
            if (arm) begin
                addr     <= '0;
                song_len <= '0;
                full     <= 1'b0;
            end else if (commit_go) begin
                addr     <= addr + ADDR_W'(1);
                song_len <= song_len + ADDR_W'(1);
            end
            if (set_full) begin
                full <= 1'b1;
            end
            if (commit_go) begin
                wr_addr     <= addr;
                wr_note     <= cur;
                wr_duration <= cnt;
                wr_isvalid  <= 1'b1;
            end else if (term_p0) begin
                wr_addr     <= addr;
                wr_note     <= NOTE_W'(TERM_NOTE);
                wr_duration <= DUR_W'(TERM_DUR);
                wr_isvalid  <= TERM_ISVALID;
            end
        end
    end

endmodule
